tx_os_scheduler: RTL and testbench

TX_OS_SCHEDULER -- requirements
Module: tx_os_scheduler

---
 rtl/tx_os_scheduler.sv | 218 +++++++++++++++++++++
 tb/tb_tx_os_scheduler.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tx_os_scheduler.sv
// tx_os_scheduler
//
// Decides, cycle by cycle, whether the transmit framing path carries data or an
// ordered set. Periodic SKP ordered sets are owed every INTERVAL non-stalled
// cycles. They are tracked as a saturating pending count and inserted at the
// next packet boundary. LTSSM ordered-set requests (TS1/TS2/EIEOS/EIOS) are
// inserted at packet boundaries too, with SKP taking priority.
//
// A cycle "advances" when i_EN=1 and i_Back_Pressure=0. A stalled cycle freezes
// everything, the registered outputs included. Dropping i_EN returns the block
// to IDLE and clears all state. An ordered set in progress is abandoned
// silently.
//
// Parameters
//   INTERVAL   non-stalled TX cycles between SKP insertions
//   CNT_WIDTH  interval counter width (INTERVAL <= 2**CNT_WIDTH)
//   OS_CYCLES  non-stalled cycles occupied by one ordered set
//   PEND_MAX   saturation limit of the pending SKP count
//
// Ports
//   CLK              clock, rising edge
//   RST              asynchronous active-high reset
//   i_EN             transmitter enable
//   i_Back_Pressure  lane-0 scrambler stall, current cycle does not advance
//   i_Pkt_Active     framing is mid-TLP/DLLP, no ordered set may start
//   i_Os_Req         LTSSM ordered-set request, held until acked
//   i_Os_Type        requested set: 0 TS1, 1 TS2, 2 EIEOS, 3 EIOS
//   o_Os_Ack         one-cycle pulse, request accepted (first OS cycle)
//   o_Os_Enable      framing mux selects the ordered-set path
//   o_Os_Sel         3'b100 SKP, 3'b0tt LTSSM type tt, else 3'b000
//   o_Hold           throttle to the data link layer write path
//   o_Skp_Pending    current pending SKP count

module tx_os_scheduler #(
  parameter int unsigned INTERVAL  = 370,
  parameter int unsigned CNT_WIDTH = 9,
  parameter int unsigned OS_CYCLES = 2,
  parameter int unsigned PEND_MAX  = 2
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       i_EN,
  input  logic       i_Back_Pressure,
  input  logic       i_Pkt_Active,
  input  logic       i_Os_Req,
  input  logic [1:0] i_Os_Type,
  output logic       o_Os_Ack,
  output logic       o_Os_Enable,
  output logic [2:0] o_Os_Sel,
  output logic       o_Hold,
  output logic [1:0] o_Skp_Pending
);

  localparam int unsigned OsW = (OS_CYCLES > 1) ? $clog2(OS_CYCLES) : 1;

  localparam logic [CNT_WIDTH-1:0] IntervalLast = CNT_WIDTH'(INTERVAL - 1);
  localparam logic [OsW-1:0]       OsLast       = OsW'(OS_CYCLES - 1);
  localparam logic [1:0]           PendMax      = 2'(PEND_MAX);

  localparam logic [2:0] SelSkp  = 3'b100;
  localparam logic [2:0] SelNone = 3'b000;

  typedef enum logic [2:0] {
    StIdle,
    StRun,
    StDrain,
    StSkp,
    StOs
  } state_e;

  state_e               state_q, state_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic [OsW-1:0]       os_cnt_q, os_cnt_d;
  logic [1:0]           pend_q, pend_d;
  logic [1:0]           type_q, type_d;

  logic                 ack_q, ack_d;
  logic                 os_en_q, os_en_d;
  logic [2:0]           sel_q, sel_d;
  logic                 hold_q, hold_d;

  logic                 advance;
  logic                 cnt_active;
  logic                 pend_inc;
  logic                 pend_dec;
  logic                 os_last;

  assign advance    = i_EN & ~i_Back_Pressure;
  assign cnt_active = (state_q == StRun) || (state_q == StDrain) || (state_q == StOs);
  assign os_last    = (os_cnt_q == OsLast);

  // Next-state logic. Stalled cycles fall through with every *_d equal to *_q.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    os_cnt_d = os_cnt_q;
    pend_d   = pend_q;
    type_d   = type_q;
    ack_d    = ack_q;
    pend_inc = 1'b0;
    pend_dec = 1'b0;

    if (!i_EN) begin
      state_d  = StIdle;
      cnt_d    = '0;
      os_cnt_d = '0;
      pend_d   = '0;
      type_d   = '0;
      ack_d    = 1'b0;
    end else if (advance) begin
      ack_d = 1'b0;

      // Interval counter: wraps and owes one more SKP.
      if (cnt_active) begin
        if (cnt_q == IntervalLast) begin
          cnt_d    = '0;
          pend_inc = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      pend_dec = (state_q == StSkp) && os_last;

      // Simultaneous increment and decrement cancel out.
      if (pend_inc && !pend_dec) begin
        pend_d = (pend_q >= PendMax) ? PendMax : pend_q + 1'b1;
      end else if (pend_dec && !pend_inc) begin
        pend_d = pend_q - 1'b1;
      end

      unique case (state_q)
        StIdle: begin
          state_d = StRun;
        end
        StRun, StDrain: begin
          // Decisions use the pending count registered at the start of this cycle.
          if (!i_Pkt_Active && (pend_q != 2'd0)) begin
            state_d  = StSkp;
            os_cnt_d = '0;
          end else if (!i_Pkt_Active && i_Os_Req) begin
            state_d  = StOs;
            os_cnt_d = '0;
            ack_d    = 1'b1;
            type_d   = i_Os_Type;
          end else if (i_Pkt_Active && ((pend_q != 2'd0) || i_Os_Req)) begin
            state_d = StDrain;
          end else begin
            state_d = StRun;
          end
        end
        StSkp: begin
          if (os_last) begin
            os_cnt_d = '0;
            state_d  = (pend_d != 2'd0) ? StSkp : StRun;
          end else begin
            os_cnt_d = os_cnt_q + 1'b1;
          end
        end
        StOs: begin
          if (os_last) begin
            os_cnt_d = '0;
            state_d  = StRun;
          end else begin
            os_cnt_d = os_cnt_q + 1'b1;
          end
        end
        default: begin
          state_d = StIdle;
        end
      endcase
    end
  end

  // Output decode from the next state, so the registered outputs track the
  // state register without a cycle of lag.
  always_comb begin
    os_en_d = (state_d == StSkp) || (state_d == StOs);
    sel_d   = SelNone;
    if (state_d == StSkp) begin
      sel_d = SelSkp;
    end else if (state_d == StOs) begin
      sel_d = {1'b0, type_d};
    end
    hold_d = (state_d != StRun) || (pend_d != 2'd0);
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      os_cnt_q <= '0;
      pend_q   <= '0;
      type_q   <= '0;
      ack_q    <= 1'b0;
      os_en_q  <= 1'b0;
      sel_q    <= SelNone;
      hold_q   <= 1'b1;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      os_cnt_q <= os_cnt_d;
      pend_q   <= pend_d;
      type_q   <= type_d;
      ack_q    <= ack_d;
      os_en_q  <= os_en_d;
      sel_q    <= sel_d;
      hold_q   <= hold_d;
    end
  end

  assign o_Os_Ack      = ack_q;
  assign o_Os_Enable   = os_en_q;
  assign o_Os_Sel      = sel_q;
  assign o_Hold        = hold_q;
  assign o_Skp_Pending = pend_q;

endmodule

// File: tb/tb_tx_os_scheduler.sv
// Bench for tx_os_scheduler with INTERVAL=8, OS_CYCLES=2, PEND_MAX=2.
// A transaction-level model predicts the outputs and is compared every cycle.
// Directed scenarios add literal checks at hand-computed cycle positions.
// Inputs change on the falling edge. Outputs are sampled on the falling edge.

module tb_tx_os_scheduler;

  localparam int unsigned INTERVAL  = 8;
  localparam int unsigned CNT_WIDTH = 4;
  localparam int unsigned OS_CYCLES = 2;
  localparam int unsigned PEND_MAX  = 2;

  localparam int S_IDLE  = 0;
  localparam int S_RUN   = 1;
  localparam int S_DRAIN = 2;
  localparam int S_SKP   = 3;
  localparam int S_OS    = 4;

  logic       CLK = 1'b0;
  logic       RST = 1'b0;
  logic       i_EN = 1'b0;
  logic       i_Back_Pressure = 1'b0;
  logic       i_Pkt_Active = 1'b0;
  logic       i_Os_Req = 1'b0;
  logic [1:0] i_Os_Type = 2'd0;
  logic       o_Os_Ack;
  logic       o_Os_Enable;
  logic [2:0] o_Os_Sel;
  logic       o_Hold;
  logic [1:0] o_Skp_Pending;

  int tests = 0;
  int fails = 0;
  bit chk_on = 1'b0;

  tx_os_scheduler #(
    .INTERVAL (INTERVAL),
    .CNT_WIDTH(CNT_WIDTH),
    .OS_CYCLES(OS_CYCLES),
    .PEND_MAX (PEND_MAX)
  ) dut (
    .CLK            (CLK),
    .RST            (RST),
    .i_EN           (i_EN),
    .i_Back_Pressure(i_Back_Pressure),
    .i_Pkt_Active   (i_Pkt_Active),
    .i_Os_Req       (i_Os_Req),
    .i_Os_Type      (i_Os_Type),
    .o_Os_Ack       (o_Os_Ack),
    .o_Os_Enable    (o_Os_Enable),
    .o_Os_Sel       (o_Os_Sel),
    .o_Hold         (o_Hold),
    .o_Skp_Pending  (o_Skp_Pending)
  );

  always #5 CLK = ~CLK;

  // Model: the scheduler as a few integers (phase, cycles since last SKP,
  // cycles spent in the current set, SKPs owed, accepted type, ack flag).
  typedef struct packed {
    int   st;
    int   cnt;
    int   os;
    int   pend;
    int   typ;
    logic ack;
  } mstate_t;

  mstate_t m;

  function automatic mstate_t model_idle();
    mstate_t r;
    r.st = S_IDLE; r.cnt = 0; r.os = 0; r.pend = 0; r.typ = 0; r.ack = 1'b0;
    return r;
  endfunction

  function automatic mstate_t model_next(mstate_t c, logic en, logic bp, logic pkt,
                                         logic req, logic [1:0] ty);
    mstate_t n;
    int inc;
    int dec;
    bit done;
    n = c;
    if (!en) return model_idle();
    if (bp) return c;
    n.ack = 1'b0;
    inc = 0;
    dec = 0;
    done = 1'b0;
    if (c.st == S_RUN || c.st == S_DRAIN || c.st == S_OS) begin
      n.cnt = c.cnt + 1;
      if (n.cnt == int'(INTERVAL)) begin
        n.cnt = 0;
        inc = 1;
      end
    end
    if (c.st == S_IDLE) begin
      n.st = S_RUN;
    end else if (c.st == S_RUN || c.st == S_DRAIN) begin
      if (!pkt && c.pend > 0) begin
        n.st = S_SKP; n.os = 0;
      end else if (!pkt && req) begin
        n.st = S_OS; n.os = 0; n.ack = 1'b1; n.typ = int'(ty);
      end else if (pkt && (c.pend > 0 || req)) begin
        n.st = S_DRAIN;
      end else begin
        n.st = S_RUN;
      end
    end else begin
      n.os = c.os + 1;
      if (n.os == int'(OS_CYCLES)) begin
        n.os = 0;
        done = 1'b1;
        if (c.st == S_SKP) dec = 1;
      end
    end
    n.pend = c.pend + inc - dec;
    if (n.pend > int'(PEND_MAX)) n.pend = int'(PEND_MAX);
    if (done) n.st = (c.st == S_SKP && n.pend > 0) ? S_SKP : S_RUN;
    return n;
  endfunction

  always @(posedge CLK or posedge RST) begin
    if (RST) m <= model_idle();
    else     m <= model_next(m, i_EN, i_Back_Pressure, i_Pkt_Active, i_Os_Req, i_Os_Type);
  end

  function automatic logic [2:0] exp_sel(mstate_t s);
    if (s.st == S_SKP) return 3'b100;
    if (s.st == S_OS)  return {1'b0, 2'(s.typ)};
    return 3'b000;
  endfunction

  function automatic logic exp_hold(mstate_t s);
    return (s.st != S_RUN) || (s.pend > 0);
  endfunction

  // Per-cycle compare against the model.
  always @(negedge CLK) begin
    if (chk_on) begin
      tests++;
      if (o_Os_Ack !== m.ack || o_Os_Enable !== (m.st == S_SKP || m.st == S_OS) ||
          o_Os_Sel !== exp_sel(m) || o_Hold !== exp_hold(m) ||
          o_Skp_Pending !== 2'(m.pend)) begin
        fails++;
        $display("FAIL model_cmp t=%0t got ack=%b en=%b sel=%b hold=%b pend=%0d want ack=%b en=%b sel=%b hold=%b pend=%0d",
                 $time, o_Os_Ack, o_Os_Enable, o_Os_Sel, o_Hold, o_Skp_Pending,
                 m.ack, (m.st == S_SKP || m.st == S_OS), exp_sel(m), exp_hold(m), m.pend);
      end
    end
  end

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s got %0d want %0d", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge CLK);
  endtask

  // Reset for one cycle, then release with the TX enabled. The release lands on
  // a falling edge; the next rising edge is "E1" in the scenario comments.
  task automatic do_reset(input logic pkt);
    @(negedge CLK);
    #2;
    RST = 1'b1;
    i_EN = 1'b0;
    i_Back_Pressure = 1'b0;
    i_Os_Req = 1'b0;
    i_Os_Type = 2'd0;
    @(negedge CLK);
    RST = 1'b0;
    i_EN = 1'b1;
    i_Pkt_Active = pkt;
  endtask

  initial begin
    #1 RST = 1'b1;
    @(negedge CLK);
    chk_on = 1'b1;
    check("rst_hold", int'(o_Hold), 1);
    check("rst_enable", int'(o_Os_Enable), 0);
    check("rst_sel", int'(o_Os_Sel), 0);
    check("rst_pend", int'(o_Skp_Pending), 0);

    // Periodic SKP: E1 IDLE->RUN, wrap at E9, SKP after E10 and E11, RUN at E12.
    do_reset(1'b0);
    tick(1);  check("s1_run_hold", int'(o_Hold), 0);
    tick(8);  check("s1_pend1", int'(o_Skp_Pending), 1);
              check("s1_no_os_yet", int'(o_Os_Enable), 0);
    tick(1);  check("s1_skp_a", int'(o_Os_Sel), 3'b100);
    tick(1);  check("s1_skp_b", int'(o_Os_Sel), 3'b100);
    tick(1);  check("s1_back_run", int'(o_Os_Enable), 0);
              check("s1_pend0", int'(o_Skp_Pending), 0);

    // Drain: packet active throughout; DRAIN after E10..E14, SKP once it drops.
    do_reset(1'b1);
    tick(9);
    for (int i = 0; i < 5; i++) begin
      tick(1);
      check("s2_drain_hold", int'(o_Hold), 1);
      check("s2_drain_no_os", int'(o_Os_Enable), 0);
    end
    i_Pkt_Active = 1'b0;
    tick(1);  check("s2_skp_start", int'(o_Os_Sel), 3'b100);
    tick(2);  check("s2_done", int'(o_Os_Enable), 0);

    // Stalls inside SKP: SKP visible after E10..E13, RUN at E14. The interval
    // counter is 1 on SKP entry and must still be 1 afterwards -> wrap at E21.
    do_reset(1'b0);
    tick(10); check("s3_skp", int'(o_Os_Sel), 3'b100);
    i_Back_Pressure = 1'b1; tick(1); check("s3_stall1", int'(o_Os_Enable), 1);
    i_Back_Pressure = 1'b0; tick(1); check("s3_adv1", int'(o_Os_Enable), 1);
    i_Back_Pressure = 1'b1; tick(1); check("s3_stall2", int'(o_Os_Enable), 1);
    i_Back_Pressure = 1'b0; tick(1); check("s3_end", int'(o_Os_Enable), 0);
    tick(6);  check("s3_pend_before_wrap", int'(o_Skp_Pending), 0);
    tick(1);  check("s3_pend_at_wrap", int'(o_Skp_Pending), 1);

    // SKP beats a pending EIEOS request; OS follows with a single ack.
    do_reset(1'b0);
    tick(9);
    i_Os_Req = 1'b1; i_Os_Type = 2'd2;
    tick(1);  check("s4_skp_first", int'(o_Os_Sel), 3'b100);
              check("s4_no_ack_skp", int'(o_Os_Ack), 0);
    tick(2);  check("s4_run_gap", int'(o_Os_Enable), 0);
    tick(1);  check("s4_ack", int'(o_Os_Ack), 1);
              check("s4_os_sel", int'(o_Os_Sel), 3'b010);
    i_Os_Req = 1'b0;
    tick(1);  check("s4_ack_once", int'(o_Os_Ack), 0);
              check("s4_os_sel2", int'(o_Os_Sel), 3'b010);
    tick(1);  check("s4_os_done", int'(o_Os_Enable), 0);

    // Saturation: wraps at E9, E17, E25 saturate at 2; two SKPs back to back.
    do_reset(1'b1);
    tick(26); check("s5_sat", int'(o_Skp_Pending), 2);
    i_Pkt_Active = 1'b0;
    tick(1);  check("s5_skp1", int'(o_Os_Sel), 3'b100);
    tick(2);  check("s5_skp2", int'(o_Os_Sel), 3'b100);
              check("s5_pend1", int'(o_Skp_Pending), 1);
    tick(2);  check("s5_done", int'(o_Os_Enable), 0);
              check("s5_pend0", int'(o_Skp_Pending), 0);
    tick(1);  check("s5_no_third", int'(o_Os_Enable), 0);

    // Enable dropped mid-OS: IDLE, everything cleared, interval restarts.
    do_reset(1'b0);
    tick(9);
    i_Os_Req = 1'b1; i_Os_Type = 2'd3;
    tick(4);  check("s6_ack", int'(o_Os_Ack), 1);
              check("s6_sel", int'(o_Os_Sel), 3'b011);
    i_Os_Req = 1'b0; i_EN = 1'b0;
    tick(1);  check("s6_idle_en", int'(o_Os_Enable), 0);
              check("s6_idle_hold", int'(o_Hold), 1);
              check("s6_idle_pend", int'(o_Skp_Pending), 0);
              check("s6_idle_sel", int'(o_Os_Sel), 0);
    i_EN = 1'b1;
    tick(1);  check("s6_no_ack", int'(o_Os_Ack), 0);
    tick(7);  check("s6_pend_before", int'(o_Skp_Pending), 0);
    tick(1);  check("s6_pend_wrap", int'(o_Skp_Pending), 1);

    // Reset in the middle of SKP discards the set; counting restarts cleanly.
    do_reset(1'b0);
    tick(10);
    #2 RST = 1'b1;
    #1 check("s7_rst_en", int'(o_Os_Enable), 0);
       check("s7_rst_hold", int'(o_Hold), 1);
       check("s7_rst_pend", int'(o_Skp_Pending), 0);
    @(negedge CLK);
    RST = 1'b0;
    tick(8);  check("s7_pend_before", int'(o_Skp_Pending), 0);
    tick(1);  check("s7_pend_wrap", int'(o_Skp_Pending), 1);

    tick(2);
    chk_on = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

endmodule
